id_decode_regfile: RTL and testbench



---
 rtl/id_decode_regfile.sv | 97 +++++++++
 tb/tb_id_decode_regfile.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/id_decode_regfile.sv
// Decode stage: instruction decode plus an 8x8 register file with a write-back port.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the operand reads.
module id_decode_regfile #(
  parameter int unsigned            DATA_W    = 8,
  parameter logic [DATA_W-1:0]      INIT_BASE = '0
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic [7:0]        Instr,
  input  logic              Flush,
  input  logic              WB_Reg_Write,
  input  logic [2:0]        WB_RD,
  input  logic [DATA_W-1:0] WB_Data,
  output logic              Reg_Write,
  output logic              ALU_OP,
  output logic [DATA_W-1:0] Data1,
  output logic [DATA_W-1:0] Data2,
  output logic [2:0]        RD
);

  localparam int unsigned NumRegs = 8;

  typedef enum logic [1:0] {
    OpNop = 2'b00,
    OpMov = 2'b01,
    OpAdd = 2'b10,
    OpSll = 2'b11
  } opcode_e;

  logic [DATA_W-1:0] regs_q [NumRegs];

  opcode_e           opcode;
  logic [2:0]        rd_idx;
  logic [2:0]        rs_idx;
  logic [DATA_W-1:0] rd_val;
  logic [DATA_W-1:0] rs_val;

  assign opcode = opcode_e'(Instr[7:6]);
  assign rd_idx = Instr[5:3];
  assign rs_idx = Instr[2:0];

  // Reset wins over write-back so a coincident write is discarded.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= INIT_BASE + DATA_W'(i);
      end
    end else if (WB_Reg_Write) begin
      regs_q[WB_RD] <= WB_Data;
    end
  end

  always_comb begin
    rd_val = regs_q[rd_idx];
    rs_val = regs_q[rs_idx];
`ifdef REGFILE_BYPASS_EN
    // Write-before-read: each operand picks up same-cycle write-back data.
    if (WB_Reg_Write && !Reset) begin
      if (WB_RD == rd_idx) rd_val = WB_Data;
      if (WB_RD == rs_idx) rs_val = WB_Data;
    end
`endif
  end

  always_comb begin
    Reg_Write = 1'b0;
    ALU_OP    = 1'b0;
    Data1     = '0;
    Data2     = '0;
    RD        = '0;
    if (!Reset && !Flush) begin
      unique case (opcode)
        OpNop: ;
        OpMov: begin
          Reg_Write = 1'b1;
          Data1     = rs_val;
          RD        = rd_idx;
        end
        OpAdd: begin
          Reg_Write = 1'b1;
          Data1     = rd_val;
          Data2     = rs_val;
          RD        = rd_idx;
        end
        OpSll: begin
          Reg_Write = 1'b1;
          ALU_OP    = 1'b1;
          Data1     = rd_val;
          Data2     = {{(DATA_W-3){1'b0}}, rs_idx};
          RD        = rd_idx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_id_decode_regfile.sv
// Scoreboard bench for id_decode_regfile: directed cases then randomized traffic against
// an array-based register model; honours REGFILE_BYPASS_EN like the design.
module tb_id_decode_regfile;

  localparam logic [7:0] InitBase = 8'h00;
`ifdef REGFILE_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  typedef struct packed {
    logic       rw;
    logic       op;
    logic [7:0] d1;
    logic [7:0] d2;
    logic [2:0] rd;
  } out_t;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [7:0] Instr = 8'h00;
  logic       Flush = 1'b0;
  logic       WB_Reg_Write = 1'b0;
  logic [2:0] WB_RD = 3'd0;
  logic [7:0] WB_Data = 8'h00;
  logic       Reg_Write;
  logic       ALU_OP;
  logic [7:0] Data1;
  logic [7:0] Data2;
  logic [2:0] RD;

  out_t       exp_q[$];
  logic [7:0] model[8];
  int         checks = 0;
  int         failures = 0;
  out_t       mon_exp;
  out_t       mon_got;

  always #5 Clk = ~Clk;

  id_decode_regfile #(
    .DATA_W   (8),
    .INIT_BASE(InitBase)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Instr       (Instr),
    .Flush       (Flush),
    .WB_Reg_Write(WB_Reg_Write),
    .WB_RD       (WB_RD),
    .WB_Data     (WB_Data),
    .Reg_Write   (Reg_Write),
    .ALU_OP      (ALU_OP),
    .Data1       (Data1),
    .Data2       (Data2),
    .RD          (RD)
  );

  function automatic logic [7:0] model_read(input logic [2:0] idx, input logic wbw,
                                            input logic [2:0] wrd, input logic [7:0] wd);
    if (Bypass && wbw && wrd == idx) return wd;
    return model[idx];
  endfunction

  // Expected decode outputs straight from the instruction table.
  function automatic out_t expect_out(input logic rst, input logic [7:0] ins, input logic fl,
                                      input logic wbw, input logic [2:0] wrd,
                                      input logic [7:0] wd);
    out_t       e;
    logic [2:0] rd;
    logic [2:0] rs;
    e  = '0;
    rd = ins[5:3];
    rs = ins[2:0];
    if (rst || fl) return e;
    case (ins[7:6])
      2'b01: e = '{rw: 1'b1, op: 1'b0, d1: model_read(rs, wbw, wrd, wd), d2: 8'h00, rd: rd};
      2'b10: e = '{rw: 1'b1, op: 1'b0, d1: model_read(rd, wbw, wrd, wd),
                   d2: model_read(rs, wbw, wrd, wd), rd: rd};
      2'b11: e = '{rw: 1'b1, op: 1'b1, d1: model_read(rd, wbw, wrd, wd), d2: {5'b0, rs}, rd: rd};
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic step(input logic rst, input logic [7:0] ins, input logic fl, input logic wbw,
                      input logic [2:0] wrd, input logic [7:0] wd);
    @(negedge Clk);
    Reset        = rst;
    Instr        = ins;
    Flush        = fl;
    WB_Reg_Write = wbw;
    WB_RD        = wrd;
    WB_Data      = wd;
    exp_q.push_back(expect_out(rst, ins, fl, wbw, wrd, wd));
    @(posedge Clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) model[i] = InitBase + 8'(i);
    end else if (wbw) begin
      model[wrd] = wd;
    end
  endtask

  // Monitor: outputs are combinational, so every cycle with a pending entry is compared.
  initial begin
    forever begin
      @(negedge Clk);
      #2;
      if (exp_q.size() != 0) begin
        mon_exp = exp_q.pop_front();
        mon_got = '{rw: Reg_Write, op: ALU_OP, d1: Data1, d2: Data2, rd: RD};
        checks++;
        if (mon_got !== mon_exp) begin
          failures++;
          $display("FAIL decode t=%0t instr=%b got rw=%b op=%b d1=%h d2=%h rd=%0d exp rw=%b op=%b d1=%h d2=%h rd=%0d",
                   $time, Instr, mon_got.rw, mon_got.op, mon_got.d1, mon_got.d2, mon_got.rd,
                   mon_exp.rw, mon_exp.op, mon_exp.d1, mon_exp.d2, mon_exp.rd);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    step(1'b1, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
    step(1'b0, 8'b10_011_101, 1'b0, 1'b0, 3'd0, 8'h00); // ADD r3,r5 -> 03,05
    step(1'b0, 8'h00, 1'b0, 1'b1, 3'd2, 8'hA7);
    step(1'b0, 8'b01_110_010, 1'b0, 1'b0, 3'd0, 8'h00); // MOV r6,r2 -> A7
    step(1'b0, 8'b11_001_011, 1'b0, 1'b0, 3'd0, 8'h00); // SLL r1,#3
    step(1'b0, 8'b10_100_100, 1'b0, 1'b1, 3'd4, 8'h5C); // ADD r4,r4 with same-cycle write
    step(1'b0, 8'b10_100_100, 1'b0, 1'b0, 3'd0, 8'h00);
    step(1'b0, 8'b10_011_101, 1'b1, 1'b1, 3'd7, 8'hFF); // flushed, write still lands
    step(1'b0, 8'b01_000_111, 1'b0, 1'b0, 3'd0, 8'h00);
    step(1'b1, 8'b01_000_001, 1'b0, 1'b1, 3'd1, 8'h99); // reset discards write
    step(1'b0, 8'b01_000_001, 1'b0, 1'b0, 3'd0, 8'h00);
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(31) == 0), 8'($urandom), ($urandom_range(7) == 0),
           1'($urandom_range(1)), 3'($urandom_range(7)), 8'($urandom));
    end
    @(negedge Clk);
    #4;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
